// File: rtl/video_spectrum_overlay.sv
// -----------------------------------------------------------------------------
// video_spectrum_overlay
//
// Draws up to NUM_BARS vertical level bars with peak-hold markers over a timed
// RGB video stream. Bar heights are written into a shadow buffer at any time.
// The shadow buffer is copied to the active buffer at each frame start, so a
// frame never shows a half-updated set of bars. Every output is the
// corresponding input delayed by exactly two pix_clk cycles, with the overlay
// colour substituted where a bar or peak marker covers the pixel.
//
// Ports:
//   pix_clk                 pixel clock, rising edge
//   rst                     synchronous active-high reset
//   vs_in, hs_in, de_in     input timing (active high)
//   r_in, g_in, b_in        input pixel, COLOR_DEPTH bits per channel
//   overlay_en              overlay enable, captured at frame start
//   bar_wr_en               shadow-buffer write strobe
//   bar_wr_addr             bar index (indices >= NUM_BARS are ignored)
//   bar_wr_data             bar height in lines
//   vs_out, hs_out, de_out  timing delayed by two cycles
//   r_out, g_out, b_out     output pixel
// -----------------------------------------------------------------------------
module video_spectrum_overlay #(
  parameter int                       COLOR_DEPTH  = 8,
  parameter int                       X_BITS       = 12,
  parameter int                       Y_BITS       = 12,
  parameter int                       H_ACT        = 1920,
  parameter int                       V_ACT        = 1080,
  parameter int                       NUM_BARS     = 32,
  parameter int                       BAR_W        = 60,
  parameter int                       BAR_GAP      = 4,
  parameter int                       BASE_Y       = 1000,
  parameter logic [3*COLOR_DEPTH-1:0] BAR_RGB      = 24'h00FF00,
  parameter logic [3*COLOR_DEPTH-1:0] PEAK_RGB     = 24'hFFFFFF,
  parameter int                       DECAY_FRAMES = 4
) (
  input  logic                   pix_clk,
  input  logic                   rst,
  input  logic                   vs_in,
  input  logic                   hs_in,
  input  logic                   de_in,
  input  logic [COLOR_DEPTH-1:0] r_in,
  input  logic [COLOR_DEPTH-1:0] g_in,
  input  logic [COLOR_DEPTH-1:0] b_in,
  input  logic                   overlay_en,
  input  logic                   bar_wr_en,
  input  logic [4:0]             bar_wr_addr,
  input  logic [7:0]             bar_wr_data,
  output logic                   vs_out,
  output logic                   hs_out,
  output logic                   de_out,
  output logic [COLOR_DEPTH-1:0] r_out,
  output logic [COLOR_DEPTH-1:0] g_out,
  output logic [COLOR_DEPTH-1:0] b_out
);

  localparam int BI_W  = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
  localparam int BC_W  = BI_W + 1;              // one extra bit to represent "past the last bar"
  localparam int OFF_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int DC_W  = $clog2(DECAY_FRAMES + 1);
  localparam int YW    = Y_BITS + 1;
  localparam int RGB_W = 3 * COLOR_DEPTH;

  // Bar and peak-marker hit tests, done one bit wider than the line counter.
  function automatic logic hit_bar(input logic [Y_BITS-1:0] y, input logic [7:0] h);
    logic [YW-1:0] top;
    top = YW'(BASE_Y) - YW'(h);
    return ({1'b0, y} >= top) && ({1'b0, y} < YW'(BASE_Y));
  endfunction

  function automatic logic hit_peak(input logic [Y_BITS-1:0] y, input logic [7:0] p);
    logic [YW-1:0] lo;
    logic [YW-1:0] hi;
    hi = YW'(BASE_Y) - YW'(p);
    lo = hi - YW'(2);
    return (p != 8'd0) && ({1'b0, y} >= lo) && ({1'b0, y} < hi);
  endfunction

  // Peak is never below the new height here, so p-1 cannot drop under h
  // unless p == h, in which case the height wins.
  function automatic logic [7:0] decay_peak(input logic [7:0] p, input logic [7:0] h);
    return (p > h) ? (p - 8'd1) : h;
  endfunction

  logic             vs_prev_q, de_prev_q, en_frame_q;
  logic [7:0]       shadow_q [NUM_BARS];
  logic [7:0]       active_q [NUM_BARS];
  logic [7:0]       peak_q   [NUM_BARS];
  logic [DC_W-1:0]  dec_q    [NUM_BARS];

  logic [X_BITS-1:0] x_q, x_d;
  logic [Y_BITS-1:0] y_q, y_d;
  logic [BC_W-1:0]   bar_q, bar_d;
  logic [OFF_W-1:0]  off_q, off_d;

  logic              vs_p1_q, hs_p1_q, de_p1_q;
  logic [RGB_W-1:0]  rgb_p1_q;
  logic [Y_BITS-1:0] y_p1_q;
  logic [BC_W-1:0]   bar_p1_q;
  logic [OFF_W-1:0]  off_p1_q;

  logic              vs_p2_q, hs_p2_q, de_p2_q;
  logic [RGB_W-1:0]  rgb_p2_q, rgb_d;

  logic              fs;
  logic              wr_ok;
  logic              in_bar;
  logic [BI_W-1:0]   idx;
  logic [7:0]        h_cur, p_cur;

  assign fs    = vs_in && !vs_prev_q;
  assign wr_ok = bar_wr_en && (32'(bar_wr_addr) < NUM_BARS);

  // Column, bar-index and in-bar offset advance together so that no divider
  // is needed; the counters hold the position of the pixel now on de_in.
  always_comb begin
    x_d   = '0;
    bar_d = '0;
    off_d = '0;
    y_d   = y_q;
    if (de_in) begin
      x_d   = (x_q == X_BITS'(H_ACT - 1)) ? x_q : x_q + 1'b1;
      bar_d = bar_q;
      off_d = off_q + 1'b1;
      if (off_q == OFF_W'(BAR_W - 1)) begin
        off_d = '0;
        bar_d = (bar_q == '1) ? bar_q : bar_q + 1'b1;
      end
    end
    if (fs) begin
      y_d = '0;
    end else if (de_prev_q && !de_in && (y_q != Y_BITS'(V_ACT - 1))) begin
      y_d = y_q + 1'b1;
    end
  end

  always_comb begin
    idx    = bar_p1_q[BI_W-1:0];
    h_cur  = active_q[idx];
    p_cur  = peak_q[idx];
    in_bar = en_frame_q && de_p1_q &&
             (bar_p1_q < BC_W'(NUM_BARS)) &&
             (off_p1_q < OFF_W'(BAR_W - BAR_GAP));
    rgb_d  = rgb_p1_q;
    if (in_bar && hit_peak(y_p1_q, p_cur)) begin
      rgb_d = PEAK_RGB;
    end else if (in_bar && hit_bar(y_p1_q, h_cur)) begin
      rgb_d = BAR_RGB;
    end
  end

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      vs_prev_q  <= 1'b0;
      de_prev_q  <= 1'b0;
      en_frame_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      bar_q      <= '0;
      off_q      <= '0;
      for (int i = 0; i < NUM_BARS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
        peak_q[i]   <= '0;
        dec_q[i]    <= '0;
      end
      vs_p1_q  <= 1'b0;
      hs_p1_q  <= 1'b0;
      de_p1_q  <= 1'b0;
      rgb_p1_q <= '0;
      y_p1_q   <= '0;
      bar_p1_q <= '0;
      off_p1_q <= '0;
      vs_p2_q  <= 1'b0;
      hs_p2_q  <= 1'b0;
      de_p2_q  <= 1'b0;
      rgb_p2_q <= '0;
    end else begin
      vs_prev_q <= vs_in;
      de_prev_q <= de_in;
      x_q       <= x_d;
      y_q       <= y_d;
      bar_q     <= bar_d;
      off_q     <= off_d;
      if (fs) en_frame_q <= overlay_en;

      // Frame start: latch shadow into active and step the peak-hold logic
      // using the freshly latched height. A write in this same cycle only
      // reaches shadow, so it shows up one frame later.
      for (int i = 0; i < NUM_BARS; i++) begin
        if (fs) begin
          active_q[i] <= shadow_q[i];
          if (shadow_q[i] > peak_q[i]) begin
            peak_q[i] <= shadow_q[i];
            dec_q[i]  <= '0;
          end else if (dec_q[i] == DC_W'(DECAY_FRAMES - 1)) begin
            peak_q[i] <= decay_peak(peak_q[i], shadow_q[i]);
            dec_q[i]  <= '0;
          end else begin
            dec_q[i]  <= dec_q[i] + 1'b1;
          end
        end
      end
      if (wr_ok) shadow_q[bar_wr_addr[BI_W-1:0]] <= bar_wr_data;

      // Stage 1: register input stream and pixel position
      vs_p1_q  <= vs_in;
      hs_p1_q  <= hs_in;
      de_p1_q  <= de_in;
      rgb_p1_q <= {r_in, g_in, b_in};
      y_p1_q   <= y_q;
      bar_p1_q <= bar_q;
      off_p1_q <= off_q;

      // Stage 2: overlay mux result
      vs_p2_q  <= vs_p1_q;
      hs_p2_q  <= hs_p1_q;
      de_p2_q  <= de_p1_q;
      rgb_p2_q <= rgb_d;
    end
  end

  assign vs_out = vs_p2_q;
  assign hs_out = hs_p2_q;
  assign de_out = de_p2_q;
  assign r_out  = rgb_p2_q[RGB_W-1 -: COLOR_DEPTH];
  assign g_out  = rgb_p2_q[2*COLOR_DEPTH-1 -: COLOR_DEPTH];
  assign b_out  = rgb_p2_q[COLOR_DEPTH-1:0];

endmodule

// File: tb/tb_video_spectrum_overlay.sv
// -----------------------------------------------------------------------------
// Bench for video_spectrum_overlay on a reduced raster: 16-pixel lines,
// 261 lines per frame, BASE_Y = 260, 4 bars of pitch 3 with a 1-pixel gap.
// Bar b covers x = 3b..3b+1 and x = 3b+2 is its gap; x >= 12 lies past the
// last bar. A behavioural model predicts every output cycle; a few fixed
// pixel coordinates are additionally compared against hand-derived colours.
// -----------------------------------------------------------------------------
module tb_video_spectrum_overlay;

  localparam int NB    = 4;
  localparam int BW    = 3;
  localparam int BG    = 1;
  localparam int BY    = 260;
  localparam int DF    = 4;
  localparam int LINES = 261;
  localparam int PIX   = 16;
  localparam logic [23:0] BAR_C  = 24'h00FF00;
  localparam logic [23:0] PEAK_C = 24'hFFFFFF;

  logic       pix_clk = 1'b0;
  logic       rst = 1'b0;
  logic       vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
  logic [7:0] r_in = '0, g_in = '0, b_in = '0;
  logic       overlay_en = 1'b0;
  logic       bar_wr_en = 1'b0;
  logic [4:0] bar_wr_addr = '0;
  logic [7:0] bar_wr_data = '0;
  logic       vs_out, hs_out, de_out;
  logic [7:0] r_out, g_out, b_out;

  always #5 pix_clk = ~pix_clk;

  video_spectrum_overlay #(
    .COLOR_DEPTH(8), .X_BITS(12), .Y_BITS(12), .H_ACT(PIX), .V_ACT(LINES),
    .NUM_BARS(NB), .BAR_W(BW), .BAR_GAP(BG), .BASE_Y(BY),
    .BAR_RGB(BAR_C), .PEAK_RGB(PEAK_C), .DECAY_FRAMES(DF)
  ) dut (
    .pix_clk(pix_clk), .rst(rst),
    .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .overlay_en(overlay_en),
    .bar_wr_en(bar_wr_en), .bar_wr_addr(bar_wr_addr), .bar_wr_data(bar_wr_data),
    .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out)
  );

  typedef struct {
    logic [26:0] v;
    int          x;
    int          y;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  logic [23:0] snap [0:LINES-1][0:PIX-1];

  // Reference model state
  int sh_m[NB], act_m[NB], pk_m[NB], dc_m[NB];
  bit en_m, vs_prev_m;

  // Stimulus controls
  bit oen = 1'b0;
  bit wr_en = 1'b0;
  int wr_addr = 0, wr_data = 0;
  bit fs_wr = 1'b0;
  int fs_wr_addr = 0, fs_wr_data = 0;
  int drop_line = -1, rst_line = -1, wr_line = -1;
  int wl_addr = 0, wl_data = 0;

  function automatic logic [23:0] colour(int x, int y);
    logic [2:0] c;
    c = 3'(x / 2);
    return {c[2] ? 8'hC0 : 8'h10, c[1] ? 8'hC0 : 8'h10, c[0] ? 8'hC0 : 8'h10} ^ 24'(y & 63);
  endfunction

  function automatic logic [23:0] junk(int n);
    return 24'h5A5A5A ^ 24'(n);
  endfunction

  function automatic logic [23:0] model_pix(int x, int y, logic [23:0] rgb);
    int b, o, h, p;
    b = x / BW;
    o = x % BW;
    if (!en_m || b >= NB || o >= BW - BG) return rgb;
    h = act_m[b];
    p = pk_m[b];
    if (p > 0 && y + p + 2 >= BY && y + p < BY) return PEAK_C;
    if (y + h >= BY && y < BY) return BAR_C;
    return rgb;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      sh_m[i] = 0; act_m[i] = 0; pk_m[i] = 0; dc_m[i] = 0;
    end
    en_m = 1'b0;
    vs_prev_m = 1'b0;
  endtask

  task automatic model_fs();
    for (int i = 0; i < NB; i++) begin
      act_m[i] = sh_m[i];
      if (act_m[i] > pk_m[i]) begin
        pk_m[i] = act_m[i];
        dc_m[i] = 0;
      end else begin
        dc_m[i]++;
        if (dc_m[i] == DF) begin
          dc_m[i] = 0;
          pk_m[i] = (pk_m[i] - 1 > act_m[i]) ? pk_m[i] - 1 : act_m[i];
        end
      end
    end
    en_m = oen;
  endtask

  // One pix_clk cycle: drive at the falling edge, predict, then compare the
  // output 1 time unit after the rising edge.
  task automatic step(input bit vs, input bit hs, input bit de, input logic [23:0] rgb,
                      input int x, input int y, input bit do_rst);
    exp_t e;
    logic [26:0] got;
    @(negedge pix_clk);
    rst = do_rst;
    vs_in = vs; hs_in = hs; de_in = de;
    {r_in, g_in, b_in} = rgb;
    overlay_en = oen;
    bar_wr_en = wr_en;
    bar_wr_addr = 5'(wr_addr);
    bar_wr_data = 8'(wr_data);
    if (do_rst) begin
      model_reset();
    end else begin
      if (vs && !vs_prev_m) model_fs();
      vs_prev_m = vs;
      if (wr_en && wr_addr < NB) sh_m[wr_addr] = wr_data;
      e.v = {vs, hs, de, de ? model_pix(x, y, rgb) : rgb};
      e.x = x;
      e.y = de ? y : -1;
      sbq.push_back(e);
    end
    @(posedge pix_clk);
    #1;
    wr_en = 1'b0;
    got = {vs_out, hs_out, de_out, r_out, g_out, b_out};
    if (do_rst) begin
      checks++;
      assert (got === 27'd0) else begin
        failures++;
        $error("FAIL reset_out obs=%h exp=%h", got, 27'd0);
      end
      // Stage 1 was cleared too, so one all-zero output follows.
      sbq.delete();
      e.v = '0; e.x = 0; e.y = -1;
      sbq.push_back(e);
    end else if (sbq.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_underflow obs=%h exp=<none>", got);
    end else begin
      e = sbq.pop_front();
      checks++;
      assert (got === e.v) else begin
        failures++;
        $error("FAIL stream x=%0d y=%0d obs=%h exp=%h", e.x, e.y, got, e.v);
      end
      if (e.y >= 0) snap[e.y][e.x] = got[23:0];
    end
  endtask

  task automatic write_idle(input int a, input int d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step(1'b0, 1'b0, 1'b0, junk(a), 0, 0, 1'b0);
  endtask

  // A frame: 3 vsync cycles (the first is the frame start), 2 blank cycles,
  // then optionally LINES active lines each followed by hsync and blanking.
  task automatic frame(input bit full);
    for (int ly = 0; ly < LINES; ly++)
      for (int lx = 0; lx < PIX; lx++) snap[ly][lx] = 'x;
    for (int i = 0; i < 3; i++) begin
      if (i == 0 && fs_wr) begin
        wr_en = 1'b1; wr_addr = fs_wr_addr; wr_data = fs_wr_data;
      end
      step(1'b1, 1'b0, 1'b0, junk(i), 0, 0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, junk(7), 0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0, junk(8), 0, 0, 1'b0);
    if (full) begin
      for (int y = 0; y < LINES; y++) begin
        if (y == drop_line) oen = 1'b0;
        for (int x = 0; x < PIX; x++) begin
          if (y == wr_line && x == 0) begin
            wr_en = 1'b1; wr_addr = wl_addr; wr_data = wl_data;
          end
          step(1'b0, 1'b0, 1'b1, colour(x, y), x, y, (y == rst_line && x == 5));
        end
        step(1'b0, 1'b1, 1'b0, junk(y), 0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, junk(y + 1), 0, 0, 1'b0);
      end
    end
    fs_wr = 1'b0; drop_line = -1; rst_line = -1; wr_line = -1;
  endtask

  task automatic spot(input string tag, input int x, input int y, input logic [23:0] exp);
    checks++;
    assert (snap[y][x] === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, snap[y][x], exp);
    end
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 24'h0, 0, 0, 1'b1);

    // Frame 1: nothing in the buffers, output is the input delayed
    oen = 1'b1;
    frame(1'b1);
    spot("f1_pass_bar0", 0, 200, colour(0, 200));
    spot("f1_pass_bar3", 9, 100, colour(9, 100));

    // bar0 = 100; write to index 5 must be dropped
    write_idle(0, 100);
    write_idle(5, 150);

    // Frame 2: bar3 = 200 written in the frame-start cycle itself
    fs_wr = 1'b1; fs_wr_addr = 3; fs_wr_data = 200;
    frame(1'b1);
    spot("f2_bar0_body",   1, 200, BAR_C);
    spot("f2_bar0_peakhi", 1, 159, PEAK_C);
    spot("f2_bar0_peaklo", 1, 158, PEAK_C);
    spot("f2_above_peak",  1, 157, colour(1, 157));
    spot("f2_bar0_top",    1, 160, BAR_C);
    spot("f2_bar0_bottom", 1, 259, BAR_C);
    spot("f2_base_line",   1, 260, colour(1, 260));
    spot("f2_gap",         2, 200, colour(2, 200));
    spot("f2_bar1_empty",  3, 200, colour(3, 200));
    spot("f2_bar3_old",    9, 100, colour(9, 100));
    spot("f2_past_bars",  12, 200, colour(12, 200));
    write_idle(2, 200);

    // Frame 3: bar3 and bar2 now visible with top at line 60
    frame(1'b1);
    spot("f3_bar3_top",   9, 60, BAR_C);
    spot("f3_bar3_peak",  9, 59, PEAK_C);
    spot("f3_bar3_peak2", 9, 58, PEAK_C);
    spot("f3_bar3_above", 9, 57, colour(9, 57));
    spot("f3_bar2_top",   6, 60, BAR_C);
    spot("f3_bar2_peak",  7, 59, PEAK_C);
    write_idle(2, 0);

    // Frame 4: bar2 body gone, peak held at 200
    frame(1'b1);
    spot("f4_p200_a",  6, 58, PEAK_C);
    spot("f4_p200_b",  6, 59, PEAK_C);
    spot("f4_no_body", 6, 60, colour(6, 60));
    spot("f4_no_body2", 6, 200, colour(6, 200));
    frame(1'b0);
    frame(1'b0);

    // Frame 7: peak 199
    frame(1'b1);
    spot("f7_p199_a",  6, 59, PEAK_C);
    spot("f7_p199_b",  6, 60, PEAK_C);
    spot("f7_p199_up", 6, 58, colour(6, 58));
    spot("f7_p199_dn", 6, 61, colour(6, 61));
    frame(1'b0);
    frame(1'b0);
    frame(1'b0);

    // Frame 11: peak 198
    frame(1'b1);
    spot("f11_p198_a",  6, 60, PEAK_C);
    spot("f11_p198_b",  6, 61, PEAK_C);
    spot("f11_p198_up", 6, 59, colour(6, 59));
    frame(1'b0);
    frame(1'b0);
    frame(1'b0);

    // Frame 15: peak 197; overlay_en drops at line 100 but the frame keeps it
    drop_line = 100;
    frame(1'b1);
    spot("f15_p197_a",  6, 61, PEAK_C);
    spot("f15_p197_b",  6, 62, PEAK_C);
    spot("f15_p197_up", 6, 60, colour(6, 60));
    spot("f15_persist0", 0, 200, BAR_C);
    spot("f15_persist3", 9, 150, BAR_C);

    // Frame 16: overlay off
    frame(1'b1);
    spot("f16_off_bar0", 0, 200, colour(0, 200));
    spot("f16_off_peak", 6, 61, colour(6, 61));
    spot("f16_off_bar3", 9, 150, colour(9, 150));
    oen = 1'b1;

    // Frame 17: reset at line 130, then bar0 = 50 written at line 200
    rst_line = 130;
    wr_line = 200; wl_addr = 0; wl_data = 50;
    frame(1'b1);
    spot("f17_pre_rst",   9, 100, BAR_C);
    spot("f17_post_rst0", 0, 200, colour(0, 200));
    spot("f17_post_rst3", 9, 150, colour(9, 150));

    // Frame 18: overlay back, only bar0 with height 50
    frame(1'b1);
    spot("f18_peak_a",  0, 208, PEAK_C);
    spot("f18_peak_b",  0, 209, PEAK_C);
    spot("f18_top",     0, 210, BAR_C);
    spot("f18_above",   0, 207, colour(0, 207));
    spot("f18_bottom",  0, 259, BAR_C);
    spot("f18_bar3_gone", 9, 100, colour(9, 100));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
